// File: rtl/guess_tracker.sv
// Memory Matrix guess engine: latches the board on start, classifies one guess per cycle as hit/miss/dup/bad.
// All outputs registered, one cycle after start/guess_valid; no back-pressure, a guess is accepted every cycle.
module guess_tracker #(
  parameter int CELLS       = 25,
  parameter int MAX_GUESSES = 7,
  parameter int IDX_W       = (CELLS > 1) ? $clog2(CELLS) : 1,
  parameter int CNT_W       = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [CELLS-1:0] board_i,
  input  logic             guess_valid_i,
  input  logic [IDX_W-1:0] guess_idx_i,
  output logic [CELLS-1:0] found_o,
  output logic [CNT_W-1:0] remaining_o,
  output logic [CNT_W-1:0] score_o,
  output logic             hit_o,
  output logic             miss_o,
  output logic             dup_o,
  output logic             bad_o,
  output logic             playing_o,
  output logic             win_o,
  output logic             lose_o
);

  typedef enum logic [1:0] {IDLE, PLAY, WIN, LOSE} state_t;

  state_t           state_q, state_d;
  logic [CELLS-1:0] board_q, board_d;
  logic [CELLS-1:0] found_q, found_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] score_q, score_d;
  logic             hit_q, hit_d;
  logic             miss_q, miss_d;
  logic             dup_q, dup_d;
  logic             bad_q, bad_d;
  logic [CELLS-1:0] guess_mask;

  assign guess_mask = {{(CELLS-1){1'b0}}, 1'b1} << guess_idx_i;

  always_comb begin
    state_d     = state_q;
    board_d     = board_q;
    found_d     = found_q;
    remaining_d = remaining_q;
    score_d     = score_q;
    hit_d       = 1'b0;
    miss_d      = 1'b0;
    dup_d       = 1'b0;
    bad_d       = 1'b0;

    // start takes priority over a coincident guess, which is dropped
    if (start_i) begin
      board_d     = board_i;
      found_d     = '0;
      remaining_d = CNT_W'(MAX_GUESSES);
      score_d     = '0;
      state_d     = (board_i != '0) ? PLAY : WIN;
    end else if (guess_valid_i && (state_q == PLAY)) begin
      if (32'(guess_idx_i) >= CELLS) begin
        bad_d = 1'b1;
      end else if (found_q[guess_idx_i]) begin
        dup_d = 1'b1;
      end else if (board_q[guess_idx_i]) begin
        hit_d   = 1'b1;
        found_d = found_q | guess_mask;
        score_d = score_q + CNT_W'(1);
        if ((found_q | guess_mask) == board_q) begin
          state_d = WIN;
        end
      end else begin
        miss_d      = 1'b1;
        remaining_d = remaining_q - CNT_W'(1);
        if (remaining_q == CNT_W'(1)) begin
          state_d = LOSE;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      board_q     <= '0;
      found_q     <= '0;
      remaining_q <= '0;
      score_q     <= '0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      dup_q       <= 1'b0;
      bad_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      board_q     <= board_d;
      found_q     <= found_d;
      remaining_q <= remaining_d;
      score_q     <= score_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      dup_q       <= dup_d;
      bad_q       <= bad_d;
    end
  end

  assign found_o     = found_q;
  assign remaining_o = remaining_q;
  assign score_o     = score_q;
  assign hit_o       = hit_q;
  assign miss_o      = miss_q;
  assign dup_o       = dup_q;
  assign bad_o       = bad_q;
  assign playing_o   = (state_q == PLAY);
  assign win_o       = (state_q == WIN);
  assign lose_o      = (state_q == LOSE);

endmodule

// File: tb/tb_guess_tracker.sv
// Bench for guess_tracker: directed scenarios plus random traffic against a round-level game model.
module tb_guess_tracker;

  localparam int CELLS = 25;
  localparam int MAXG  = 7;
  localparam int IDX_W = 5;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [CELLS-1:0] board = '0;
  logic             gv = 1'b0;
  logic [IDX_W-1:0] gidx = '0;
  logic [CELLS-1:0] found;
  logic [CNT_W-1:0] remaining, score;
  logic             hit, miss, dup, bad, playing, win, lose;
  logic [47:0]      obs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  guess_tracker #(.CELLS(CELLS), .MAX_GUESSES(MAXG), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .reset_i(rst), .start_i(start), .board_i(board),
    .guess_valid_i(gv), .guess_idx_i(gidx),
    .found_o(found), .remaining_o(remaining), .score_o(score),
    .hit_o(hit), .miss_o(miss), .dup_o(dup), .bad_o(bad),
    .playing_o(playing), .win_o(win), .lose_o(lose)
  );

  assign obs = {found, remaining, score, hit, miss, dup, bad, playing, win, lose};

  // Game model: 0 idle, 1 playing, 2 won, 3 lost
  logic [CELLS-1:0] m_board = '0;
  logic [CELLS-1:0] m_found = '0;
  int               m_rem = 0;
  int               m_mode = 0;
  bit               m_hit, m_miss, m_dup, m_bad;

  function automatic logic [47:0] exp_vec();
    return {m_found, 8'(m_rem), 8'($countones(m_found)), m_hit, m_miss, m_dup, m_bad,
            m_mode == 1, m_mode == 2, m_mode == 3};
  endfunction

  task automatic model_step(input bit r, input bit s, input logic [CELLS-1:0] b,
                            input bit g, input int idx);
    {m_hit, m_miss, m_dup, m_bad} = 4'b0;
    if (r) begin
      m_board = '0; m_found = '0; m_rem = 0; m_mode = 0;
    end else if (s) begin
      m_board = b; m_found = '0; m_rem = MAXG;
      m_mode  = (b == 0) ? 2 : 1;
    end else if (g && m_mode == 1) begin
      if (idx >= CELLS) m_bad = 1;
      else if (m_found[idx]) m_dup = 1;
      else if (m_board[idx]) begin
        m_hit = 1;
        m_found[idx] = 1'b1;
        if (m_found == m_board) m_mode = 2;
      end else begin
        m_miss = 1;
        m_rem  = m_rem - 1;
        if (m_rem == 0) m_mode = 3;
      end
    end
  endtask

  // One clock: drive, advance model, sample 1 time unit after the edge
  task automatic tick(input bit r, input bit s, input logic [CELLS-1:0] b,
                      input bit g, input int idx);
    rst = r; start = s; board = b; gv = g; gidx = IDX_W'(idx);
    @(posedge clk);
    model_step(r, s, b, g, idx);
    #1;
    rst = 0; start = 0; gv = 0;
  endtask

  task automatic test_reset();
    tick(1, 0, '0, 0, 0);
    checks++;
    if (obs !== 48'h0) begin
      errors++; $display("FAIL reset_state: got %h want %h", obs, 48'h0);
    end
  endtask

  task automatic test_win();
    int seq[3] = '{0, 1, 4};
    tick(0, 1, 25'h13, 0, 0);
    checks++;
    if ({playing, remaining, score, found} !== {1'b1, 8'd7, 8'd0, 25'h0}) begin
      errors++; $display("FAIL start_load: got %h want %h", {playing, remaining, score, found},
                         {1'b1, 8'd7, 8'd0, 25'h0});
    end
    foreach (seq[i]) begin
      tick(0, 0, '0, 1, seq[i]);
      checks++;
      if (obs !== exp_vec() || hit !== 1'b1) begin
        errors++; $display("FAIL win_hit%0d: got %h want %h", i, obs, exp_vec());
      end
    end
    checks++;
    if ({score, found, win, playing} !== {8'd3, 25'h13, 1'b1, 1'b0}) begin
      errors++; $display("FAIL win_final: got %h want %h", {score, found, win, playing},
                         {8'd3, 25'h13, 1'b1, 1'b0});
    end
    tick(0, 0, '0, 1, 2);
    checks++;
    if ({hit, miss, dup, bad} !== 4'b0 || obs !== exp_vec()) begin
      errors++; $display("FAIL win_ignore: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_lose();
    int seq[7] = '{2, 3, 5, 6, 7, 8, 9};
    tick(0, 1, 25'h13, 0, 0);
    foreach (seq[i]) begin
      tick(0, 0, '0, 1, seq[i]);
      checks++;
      if (miss !== 1'b1 || remaining !== 8'(6 - i) || lose !== (i == 6) || obs !== exp_vec()) begin
        errors++; $display("FAIL lose_miss%0d: got %h want %h", i, obs, exp_vec());
      end
    end
    tick(0, 0, '0, 1, 0);
    checks++;
    if (found !== 25'h0 || hit !== 1'b0 || lose !== 1'b1) begin
      errors++; $display("FAIL lose_ignore: got found=%h hit=%b lose=%b want 0 0 1", found, hit, lose);
    end
  endtask

  task automatic test_dup_bad();
    tick(0, 1, 25'h13, 0, 0);
    tick(0, 0, '0, 1, 0);
    tick(0, 0, '0, 1, 0);
    checks++;
    if ({dup, hit, score, remaining} !== {1'b1, 1'b0, 8'd1, 8'd7}) begin
      errors++; $display("FAIL dup: got %h want %h", {dup, hit, score, remaining}, {1'b1, 1'b0, 8'd1, 8'd7});
    end
    tick(0, 0, '0, 1, 31);
    checks++;
    if (bad !== 1'b1 || obs !== exp_vec() || found !== 25'h1) begin
      errors++; $display("FAIL bad_idx: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_last_guess_win();
    int seq[9] = '{2, 3, 5, 6, 7, 8, 0, 1, 4};
    tick(0, 1, 25'h13, 0, 0);
    foreach (seq[i]) begin
      tick(0, 0, '0, 1, seq[i]);
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL lastwin_step%0d: got %h want %h", i, obs, exp_vec());
      end
    end
    checks++;
    if ({remaining, win, lose} !== {8'd1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL lastwin_final: got %h want %h", {remaining, win, lose}, {8'd1, 1'b1, 1'b0});
    end
  endtask

  task automatic test_empty_board();
    tick(0, 1, '0, 0, 0);
    checks++;
    if ({win, playing, lose} !== 3'b100) begin
      errors++; $display("FAIL empty_board: got %b want 100", {win, playing, lose});
    end
  endtask

  task automatic test_start_override();
    tick(0, 1, 25'h13, 0, 0);
    tick(0, 0, '0, 1, 2);
    tick(0, 1, 25'h13, 1, 0);
    checks++;
    if ({remaining, score, hit, miss, dup, bad, playing} !== {8'd7, 8'd0, 4'b0, 1'b1} ||
        obs !== exp_vec()) begin
      errors++; $display("FAIL start_override: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_mid_reset();
    tick(0, 1, 25'h13, 0, 0);
    tick(0, 0, '0, 1, 0);
    tick(0, 0, '0, 1, 2);
    tick(1, 0, '0, 1, 1);
    checks++;
    if (obs !== 48'h0) begin
      errors++; $display("FAIL mid_reset: got %h want %h", obs, 48'h0);
    end
  endtask

  task automatic test_back_to_back_random();
    for (int n = 0; n < 600; n++) begin
      bit               r, s, g;
      logic [CELLS-1:0] b;
      int               idx;
      r   = ($urandom_range(0, 99) == 0);
      s   = ($urandom_range(0, 29) == 0);
      b   = CELLS'($urandom) & CELLS'($urandom) & CELLS'($urandom);
      if ($urandom_range(0, 9) == 0) b = '0;
      g   = ($urandom_range(0, 9) < 8);
      idx = $urandom_range(0, 31);
      if ($urandom_range(0, 4) == 0) idx = int'(gidx);
      tick(r, s, b, g, idx);
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL random_cyc%0d: got %h want %h", n, obs, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_win();
    test_lose();
    test_dup_bad();
    test_last_guess_win();
    test_empty_board();
    test_start_override();
    test_mid_reset();
    test_back_to_back_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/guess_tracker.md
# guess_tracker

Parametrised guess-processing engine for the Memory Matrix game. It latches the hidden tile board at round start and accepts one tile-index guess per handshake. For each guess it classifies hit, miss, repeat or invalid, and accumulates the correctly found tiles. It counts down remaining guesses and declares win or lose. It sits between the input/debounce logic and the display/round controller, replacing the single-shot remaining-guess counter and guess checker.

## Interface
- CELLS, 25: number of board tiles (5x5 default); legal range 1..64
- MAX_GUESSES, 7: wrong guesses allowed per round; legal range 1..255
- IDX_W, $clog2(CELLS): width of guess index
- CNT_W, 8: width of remaining-guess and score counters
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; returns block to IDLE
- start  in  1  one-cycle pulse; latches board, loads counters, enters PLAY
- board  in  CELLS  hidden pattern, bit i = 1 means tile i is lit; sampled only on start
- guess_valid  in  1  one-cycle pulse, guess_idx is valid
- guess_idx  in  IDX_W  tile index guessed
- found  out  CELLS  tiles correctly guessed so far this round
- remaining  out  CNT_W  wrong guesses still allowed
- score  out  CNT_W  number of distinct hits this round
- hit, miss, dup, bad  out  1 each  one-cycle result pulses
- playing  out  1  high in PLAY
- win, lose  out  1 each  level, high in WIN / LOSE respectively

## Operation
- States: IDLE, PLAY, WIN, LOSE. Encoding is free.
- Reset values: state IDLE; found 0; remaining 0; score 0; all pulses 0; playing, win and lose 0; latched board 0.
- start, accepted in any state: board_q <= board, found <= 0, remaining <= MAX_GUESSES, score <= 0, pulses cleared.
  - Next state is PLAY if board != 0, otherwise WIN.
- guess_valid in PLAY, evaluated in priority order:
  - guess_idx >= CELLS: bad pulse; no other change.
  - found[guess_idx] = 1: dup pulse; no counter change (repeats are free).
  - board_q[guess_idx] = 1: hit pulse; found[guess_idx] <= 1; score <= score + 1.
  - otherwise: miss pulse; remaining <= remaining - 1.
    - Re-guessing a previously missed tile is a miss again.
- Transitions out of PLAY:
  - After a hit where the updated found == board_q, go to WIN.
  - After a miss where remaining was 1 (becomes 0), go to LOSE.
  - A hit never decrements remaining, so a win on the last guess is possible.
- guess_valid in IDLE, WIN or LOSE is ignored: no pulse, no state change.
- WIN and LOSE hold found, remaining and score stable for display until the next start or reset.
- Arithmetic is unsigned.
  - remaining never underflows; it saturates at 0 by construction because LOSE is entered at 0.
  - score is bounded by CELLS.

## Timing
- All outputs are registered.
- Result pulse, found, score and remaining update one cycle after the guess_valid edge.
- win, lose and playing change in that same cycle.
- start to playing high: 1 cycle.
- Back-to-back guess_valid on consecutive cycles is supported.
  - Each guess is evaluated against found as updated by the previous guess.
  - A repeated index on the next cycle yields dup.
- start and guess_valid in the same cycle: start wins and the guess is dropped.
- reset overrides start and guess_valid.
- Reset mid-round clears everything to reset values on the next edge.
- No back-pressure: the block always accepts guesses at one per cycle.

## Test plan
- Reset, then start with board=25'h0000_0013, CELLS=25, MAX_GUESSES=7 -> next cycle: playing=1, remaining=7, score=0, found=0.
- Guesses 0, 1, 4 on consecutive cycles -> hit pulses on 3 cycles; score=3; found=0x13; win=1 after the third; a subsequent guess_valid produces no pulse.
- Same board; guesses 2, 3, 5, 6, 7, 8, 9 -> 7 miss pulses; remaining goes 6..0; lose=1 on the seventh.
  - A guess 0 afterwards is ignored; found stays 0.
- Guess 0, then 0 again -> hit, then dup; score=1; remaining=7.
  - Then guess 31 (>= 25) -> bad; nothing else changes.
- Six misses (remaining=1), then guesses 0, 1, 4 -> remaining stays 1; win=1, lose=0.
- start with board=0 -> win=1 next cycle.
- start asserted in the same cycle as guess_valid mid-round -> round restarts with remaining=7 and no result pulse.
- reset asserted mid-PLAY -> all outputs return to reset values.
